ram_rom_mem: RTL and testbench
==============================

Name: ram_rom_mem

Overview:
Parametrised single-port synchronous RAM that preloads itself from a built-in ROM pattern after reset. It then serves read and write requests over a valid/ready handshake, with registered read data. It replaces the fixed 4x4 combinational lookup in the lab top: the top drives it from SWI and shows rd_data on LED.

Parameters:
ADDR_WIDTH, 2, address bits; DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 4, bits per word

Ports:
clk_2  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
init_start  input  1  pulse in READY re-runs the ROM preload without reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  word address
req_wdata  input  DATA_WIDTH  write data
perr_inject  input  1  flips the stored parity bit on a write (test hook)
rd_valid  output  1  rd_data carries a new read result this cycle
rd_data  output  DATA_WIDTH  registered read data
rd_perr  output  1  parity error flag, qualified by rd_valid
init_done  output  1  high while in READY

Behaviour:
- One clock, clk_2. Reset is synchronous and active-high.
- Reset values: state=INIT, init_addr=0, rd_valid=0, rd_data=0, rd_perr=0, init_done=0. The memory array itself is not reset.
- ROM pattern: rom(i) = (3*(i+1)) mod 2**DATA_WIDTH. Defaults give 0011, 0110, 1001, 1100.
- FSM state INIT:
  - Each cycle: mem[init_addr] <= rom(init_addr), then init_addr increments.
  - After the write at init_addr = DEPTH-1: next state is READY and init_addr wraps to 0.
  - Takes exactly DEPTH cycles. init_done rises at the edge ending the DEPTH-th cycle after reset is sampled low.
- FSM state READY: init_done=1. init_start=1 returns to INIT, sets init_addr=0 and init_done=0.
- req_ready = (state==READY) && !init_start, purely combinational.
- A transfer happens when req_valid && req_ready at a rising edge.
  - Write transfer: mem[req_addr] <= req_wdata. rd_valid=0 next cycle.
  - Read transfer: rd_data <= mem[req_addr] and rd_valid=1 in the next cycle only. Latency is 1 cycle.
  - Back-to-back reads produce consecutive rd_valid pulses, one result per cycle.
- When rd_valid=0, rd_data holds its last value.
- A read in the cycle after a write to the same address returns the new data.
- Requests during INIT, or in a cycle with init_start=1, are not accepted: no write and no rd_valid. The requester keeps req_valid asserted until accepted.
- Reset mid-operation (including mid-INIT) restarts INIT at address 0. All earlier writes are overwritten with the ROM pattern.
- Address and counter arithmetic is ADDR_WIDTH wide and wraps modulo DEPTH.

Optional Feature:
Macro RAM_ROM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, written as ^data during INIT and on writes. On a write, the stored bit is inverted when perr_inject=1.
  - A read sets rd_perr = (^stored_data != stored_parity) together with rd_valid. rd_perr clears in the next cycle unless another read also has an error.
- Not defined: no parity storage, perr_inject is ignored, and rd_perr is constant 0.

Decomposition:
- Package ram_rom_pkg holds:
  - state enum {INIT, READY}
  - rom_word(i) function, parametrised by DATA_WIDTH
- One sub-module is natural: ram_init_rom, a combinational ROM mapping init_addr to the preload word (and its parity bit when the macro is defined).
- FSM, handshake and array stay in ram_rom_mem.

Test Plan:
- Reset for 2 cycles, then release -> init_done=0 and req_ready=0 for 4 cycles, then init_done=1. Reads of addr 0..3 return 0011, 0110, 1001, 1100, each 1 cycle after its transfer.
- Write addr 1 = 1111, then read addr 1 in the next cycle -> rd_valid=1, rd_data=1111. Read addr 2 -> 1001 (unaffected).
- Write addr 3 = 0000, then assert reset mid-INIT and re-run init -> addr 3 reads 1100 again. No rd_valid appears during INIT.
- In READY, req_valid=1 read addr 0 together with init_start=1 -> req_ready=0, no transfer, 4-cycle INIT follows. The request held high is accepted after init_done and returns 0011.
- Four back-to-back reads of addr 3,2,1,0 -> rd_valid high 4 consecutive cycles with data 1100, 1001, 0110, 0011. rd_data holds 0011 afterwards.
- With RAM_ROM_PARITY_EN: write addr 0 = 0101 with perr_inject=1, then read -> rd_perr=1. Read addr 1 -> rd_perr=0.

Source files
------------

// File: rtl/ram_rom_pkg.sv
// Shared types and the preload pattern for the self-initialising RAM.
// Used by ram_rom_mem and ram_init_rom (parity option: RAM_ROM_PARITY_EN).
package ram_rom_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  // Preload word for index idx, truncated to dw bits: (3*(idx+1)) mod 2**dw.
  function automatic logic [31:0] rom_word(input int unsigned idx, input int unsigned dw);
    logic [31:0] v;
    logic [31:0] mask;
    v    = 32'(3 * (idx + 1));
    mask = (dw >= 32) ? '1 : ((32'd1 << dw) - 32'd1);
    return v & mask;
  endfunction

endpackage

// File: rtl/ram_init_rom.sv
// Combinational ROM giving the preload word (and, with RAM_ROM_PARITY_EN,
// its even-parity bit) for the current init address.
module ram_init_rom
  import ram_rom_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
`ifdef RAM_ROM_PARITY_EN
  output logic                  parity_o,
`endif
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [31:0] word_full;
  logic        unused_hi;

  assign word_full = rom_word(32'(addr_i), 32'(DATA_WIDTH));
  assign data_o    = word_full[DATA_WIDTH-1:0];
  assign unused_hi = ^word_full[31:DATA_WIDTH];

`ifdef RAM_ROM_PARITY_EN
  assign parity_o = ^data_o;
`endif

endmodule

// File: rtl/ram_rom_mem.sv
// Single-port synchronous RAM that preloads itself from a ROM pattern after
// reset, then serves valid/ready requests. Optional parity: RAM_ROM_PARITY_EN.
module ram_rom_mem
  import ram_rom_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  init_start,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  perr_inject,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_perr,
  output logic                  init_done,
  output state_t                dbg_state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // the requester holds req_valid and the request fields stable until then.

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] init_addr_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_perr_q;
  logic                  init_done_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DATA_WIDTH-1:0] rom_data;
  logic                  xfer, wr_xfer, rd_xfer;
  logic                  mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_waddr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic                  rd_perr_d;

  assign req_ready = (state_q == READY) && !init_start;
  assign xfer      = req_valid && req_ready;
  assign wr_xfer   = xfer && req_we;
  assign rd_xfer   = xfer && !req_we;

`ifdef RAM_ROM_PARITY_EN
  logic                  rom_par;
  logic                  mem_wpar_d;
  logic                  mem_par_q [DEPTH];

  ram_init_rom #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rom (
    .addr_i  (init_addr_q),
    .parity_o(rom_par),
    .data_o  (rom_data)
  );
`else
  logic unused_perr;
  assign unused_perr = perr_inject;

  ram_init_rom #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rom (
    .addr_i(init_addr_q),
    .data_o(rom_data)
  );
`endif

  // Array write port is shared by the preload sequencer and write requests.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = init_addr_q;
    mem_wdata_d = rom_data;
`ifdef RAM_ROM_PARITY_EN
    mem_wpar_d  = rom_par;
`endif
    if (state_q == INIT) begin
      mem_we_d = !reset;
    end else if (wr_xfer) begin
      mem_we_d    = !reset;
      mem_waddr_d = req_addr;
      mem_wdata_d = req_wdata;
`ifdef RAM_ROM_PARITY_EN
      mem_wpar_d  = (^req_wdata) ^ perr_inject;
`endif
    end
  end

  always_ff @(posedge clk_2) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
`ifdef RAM_ROM_PARITY_EN
      mem_par_q[mem_waddr_d] <= mem_wpar_d;
`endif
    end
  end

`ifdef RAM_ROM_PARITY_EN
  assign rd_perr_d = (^mem_q[req_addr]) != mem_par_q[req_addr];
`else
  assign rd_perr_d = 1'b0;
`endif

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q     <= INIT;
      init_addr_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_perr_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_xfer;
      rd_perr_q  <= rd_xfer && rd_perr_d;
      if (rd_xfer) begin
        rd_data_q <= mem_q[req_addr];
      end
      case (state_q)
        INIT: begin
          init_addr_q <= init_addr_q + ADDR_WIDTH'(1);
          if (init_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
            state_q     <= READY;
            init_done_q <= 1'b1;
          end
        end
        READY: begin
          if (init_start) begin
            state_q     <= INIT;
            init_addr_q <= '0;
            init_done_q <= 1'b0;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_perr   = rd_perr_q;
  assign init_done = init_done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_rom_mem.sv
// Directed bench for ram_rom_mem: reference memory model plus a queue of
// expected read results checked whenever rd_valid is seen.
module tb_ram_rom_mem;
  import ram_rom_pkg::*;

  localparam int AW    = 2;
  localparam int DW    = 4;
  localparam int DEPTH = 4;
`ifdef RAM_ROM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk_2;
  logic          reset;
  logic          init_start;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          perr_inject;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_perr;
  logic          init_done;
  state_t        dbg_state;

  int total = 0;
  int bad   = 0;

  logic [DW:0]   exp_q[$];   // {perr, data}
  logic [DW-1:0] model_mem [DEPTH];
  logic          model_perr [DEPTH];

  ram_rom_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .init_start (init_start),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .perr_inject(perr_inject),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_perr    (rd_perr),
    .init_done  (init_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rom_model(input int i);
    return DW'((3 * (i + 1)) % (1 << DW));
  endfunction

  task automatic model_init();
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i]  = rom_model(i);
      model_perr[i] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  // Holds a request until accepted; updates the model / queue on the transfer edge.
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic inj, output int waited);
    bit accepted;
    accepted    = 1'b0;
    waited      = 0;
    req_valid   = 1'b1;
    req_we      = we;
    req_addr    = addr;
    req_wdata   = wdata;
    perr_inject = inj;
    while (!accepted && waited < 20) begin
      if (req_ready === 1'b1) begin
        accepted = 1'b1;
        if (we) begin
          model_mem[addr]  = wdata;
          model_perr[addr] = PAR_EN & inj;
        end else begin
          exp_q.push_back({PAR_EN & model_perr[addr], model_mem[addr]});
        end
      end else begin
        waited++;
      end
      tick();
    end
    req_valid   = 1'b0;
    perr_inject = 1'b0;
    if (!accepted) check("req_timeout", 32'd0, 32'd1);
  endtask

  // Counts cycles until init_done, checking that no request is accepted meanwhile.
  task automatic wait_init(output int cycles);
    cycles = 0;
    while (init_done !== 1'b1 && cycles < 20) begin
      check("ready_during_init", 32'(req_ready), 32'd0);
      tick();
      cycles++;
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk_2) begin
    logic [DW:0] e;
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(e[DW-1:0]));
        check("rd_perr", 32'(rd_perr), 32'(e[DW]));
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    reset       = 1'b1;
    init_start  = 1'b0;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    perr_inject = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset values, then exactly DEPTH cycles of preload.
    @(negedge clk_2);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_rd_valid",  32'(rd_valid),  32'd0);
    check("rst_rd_data",   32'(rd_data),   32'd0);
    check("rst_rd_perr",   32'(rd_perr),   32'd0);
    check("rst_state",     32'(dbg_state), 32'(INIT));
    wait_init(w);
    check("init_cycles", 32'(w), 32'd4);
    check("ready_after_init", 32'(req_ready), 32'd1);
    check("state_ready", 32'(dbg_state), 32'(READY));
    model_init();

    // Preload contents.
    for (int a = 0; a < DEPTH; a++) do_req(1'b0, AW'(a), '0, 1'b0, w);
    tick();

    // Write then read-after-write, neighbour unaffected.
    do_req(1'b1, 2'd1, 4'b1111, 1'b0, w);
    @(negedge clk_2);
    check("wr_no_rd_valid", 32'(rd_valid), 32'd0);
    do_req(1'b0, 2'd1, '0, 1'b0, w);
    do_req(1'b0, 2'd2, '0, 1'b0, w);
    tick();

    // Write addr 3, re-init, reset mid-INIT: preload restored.
    do_req(1'b1, 2'd3, 4'b0000, 1'b0, w);
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_init(w);
    check("reinit_cycles", 32'(w), 32'd4);
    model_init();
    do_req(1'b0, 2'd3, '0, 1'b0, w);
    tick();

    // Request held through an init_start pulse.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 2'd0;
    init_start = 1'b1;
    #1;
    check("ready_with_init_start", 32'(req_ready), 32'd0);
    tick();
    init_start = 1'b0;
    model_init();
    do_req(1'b0, 2'd0, '0, 1'b0, w);
    check("held_req_wait", 32'(w), 32'd4);

    // Back-to-back reads, then rd_data holds.
    do_req(1'b0, 2'd3, '0, 1'b0, w);
    check("b2b_wait0", 32'(w), 32'd0);
    do_req(1'b0, 2'd2, '0, 1'b0, w);
    check("b2b_wait1", 32'(w), 32'd0);
    do_req(1'b0, 2'd1, '0, 1'b0, w);
    do_req(1'b0, 2'd0, '0, 1'b0, w);
    tick();
    tick();
    @(negedge clk_2);
    check("idle_rd_valid", 32'(rd_valid), 32'd0);
    check("hold_rd_data", 32'(rd_data), 32'(4'b0011));

    // Parity injection (ignored without the parity option).
    do_req(1'b1, 2'd0, 4'b0101, 1'b1, w);
    do_req(1'b0, 2'd0, '0, 1'b0, w);
    do_req(1'b0, 2'd1, '0, 1'b0, w);
    do_req(1'b1, 2'd2, 4'b0111, 1'b0, w);
    do_req(1'b0, 2'd2, '0, 1'b0, w);
    tick();
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
